// File: rtl/iram_prog_if.sv
// Fetch and byte-loader bus of the run-time-loadable instruction memory.
interface iram_prog_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic              im_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              addr_err;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_err;
    logic [ADDR_W:0]   ld_count;

    // Memory side
    modport slave (
        input  im_r, addr, ld_start, ld_base, ld_valid, ld_byte, ld_last,
        output instr_out, instr_valid, addr_err,
        output ld_ready, ld_busy, ld_done, ld_err, ld_count
    );

    // Fetch stage / loader side
    modport master (
        output im_r, addr, ld_start, ld_base, ld_valid, ld_byte, ld_last,
        input  instr_out, instr_valid, addr_err,
        input  ld_ready, ld_busy, ld_done, ld_err, ld_count
    );
endinterface

// File: rtl/iram_prog.sv
// Instruction memory with registered fetch port and byte-serial program loader.
module iram_prog #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic         clock,
    input  logic         reset_n,
    iram_prog_if.slave   bus
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] asm_buf, buf_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              err, err_nxt;

    logic              we_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] shifted_c;
    logic              ptr_ok_c;
    logic              fetch_ok_c;

    logic              instr_valid_q, addr_err_q;
    logic [DATA_W-1:0] instr_q;
    logic              ready_q, busy_q, done_q;

    logic [DATA_W-1:0] mem [DEPTH];

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and loader datapath; a partial word is left-aligned and zero-padded on ld_last
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        buf_nxt   = asm_buf;
        count_nxt = count;
        err_nxt   = err;
        we_c      = 1'b0;
        wdata_c   = '0;
        shifted_c = (asm_buf << 8) | DATA_W'(bus.ld_byte);
        ptr_ok_c  = {1'b0, ptr} < CNT_W'(DEPTH);
        case (state)
            IDLE: begin
                if (bus.ld_start) begin
                    state_nxt = LOAD;
                    ptr_nxt   = bus.ld_base;
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                    idx_nxt   = '0;
                    buf_nxt   = '0;
                end
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    buf_nxt = shifted_c;
                    idx_nxt = idx + 1'b1;
                    if (idx == IDX_W'(BYTES - 1) || bus.ld_last) begin
                        wdata_c   = shifted_c << (8 * (IDX_W'(BYTES - 1) - idx));
                        we_c      = ptr_ok_c;
                        err_nxt   = err | ~ptr_ok_c;
                        ptr_nxt   = ptr + 1'b1;
                        count_nxt = count + 1'b1;
                        idx_nxt   = '0;
                        buf_nxt   = '0;
                        if (bus.ld_last) state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Loader registers and status flags derived from the next state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr     <= '0;
            idx     <= '0;
            asm_buf <= '0;
            count   <= '0;
            err     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            idx     <= idx_nxt;
            asm_buf <= buf_nxt;
            count   <= count_nxt;
            err     <= err_nxt;
            ready_q <= (state_nxt == LOAD);
            busy_q  <= (state_nxt != IDLE);
            done_q  <= (state_nxt == DONE);
        end
    end

    // Program storage; contents survive reset
    always_ff @(posedge clock) begin
        if (we_c && reset_n) mem[ptr] <= wdata_c;
    end

    assign fetch_ok_c = {1'b0, bus.addr} < CNT_W'(DEPTH);

    // Registered fetch port, served only while the loader is idle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else if (state == IDLE && bus.im_r) begin
            instr_q       <= fetch_ok_c ? mem[bus.addr] : '0;
            instr_valid_q <= 1'b1;
            addr_err_q    <= ~fetch_ok_c;
        end else begin
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end
    end

    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.ld_ready    = ready_q;
    assign bus.ld_busy     = busy_q;
    assign bus.ld_done     = done_q;
    assign bus.ld_err      = err;
    assign bus.ld_count    = count;
endmodule

// File: tb/tb_iram_prog.sv
// Scoreboard bench for iram_prog: random load sessions and fetches against a word-array model.
module tb_iram_prog;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DEPTH  = 100;
    localparam int unsigned SPACE  = 1 << ADDR_W;

    typedef struct {logic [DATA_W-1:0] data; logic err;} fetch_exp_t;
    typedef struct {int count; logic err;} load_exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    iram_prog_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    iram_prog #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    fetch_exp_t        fetch_q[$];
    load_exp_t         load_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    int                errors = 0;
    int                checks = 0;
    logic [DATA_W-1:0] hold = '0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT reports a fetch or session end
    always @(negedge clock) begin
        if (!reset_n) begin
            hold = '0;
        end else begin
            if (bus.instr_valid) begin
                if (fetch_q.size() == 0) begin
                    chk("unexpected_instr_valid", 1, 0);
                end else begin
                    fetch_exp_t e;
                    e = fetch_q.pop_front();
                    chk("instr_out", bus.instr_out, e.data);
                    chk("addr_err", bus.addr_err, e.err);
                    hold = e.data;
                end
            end else begin
                chk("instr_hold", bus.instr_out, hold);
                chk("addr_err_idle", bus.addr_err, 0);
            end
            if (bus.ld_done) begin
                if (load_q.size() == 0) begin
                    chk("unexpected_ld_done", 1, 0);
                end else begin
                    load_exp_t l;
                    l = load_q.pop_front();
                    chk("ld_count", bus.ld_count, l.count);
                    chk("ld_err", bus.ld_err, l.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void expect_fetch(int a);
        fetch_exp_t e;
        e.err  = (a >= int'(DEPTH));
        e.data = e.err ? '0 : model[a];
        fetch_q.push_back(e);
    endfunction

    task automatic fetch(input int a);
        bus.im_r = 1'b1;
        bus.addr = ADDR_W'(a);
        expect_fetch(a);
        tick();
        bus.im_r = 1'b0;
    endtask

    // Expected outcome of a session: bytes packed MSB-first, last word zero-padded
    function automatic void model_session(int base, logic [7:0] bytes[$], bit push);
        int n = bytes.size();
        int words = (n + 3) / 4;
        load_exp_t l;
        l.count = words;
        l.err = 1'b0;
        for (int w = 0; w < words; w++) begin
            int a = (base + w) % SPACE;
            logic [DATA_W-1:0] word = '0;
            for (int b = 0; b < 4; b++) begin
                int k = w * 4 + b;
                word = (word << 8) | DATA_W'((k < n) ? bytes[k] : 8'h00);
            end
            if (a < int'(DEPTH)) model[a] = word;
            else l.err = 1'b1;
        end
        if (push) load_q.push_back(l);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit last, input bit poke);
        int g = 0;
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        if (poke) begin
            bus.im_r = 1'b1;
            bus.addr = ADDR_W'($urandom_range(0, SPACE - 1));
        end
        while (!bus.ld_ready && g < 20) begin
            tick();
            g++;
        end
        if (g == 20) chk("ld_ready_timeout", 0, 1);
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.im_r     = 1'b0;
    endtask

    task automatic start_session(input int base, input int fetch_addr);
        bus.ld_start = 1'b1;
        bus.ld_base  = ADDR_W'(base);
        if (fetch_addr >= 0) begin
            bus.im_r = 1'b1;
            bus.addr = ADDR_W'(fetch_addr);
            expect_fetch(fetch_addr);
        end
        tick();
        bus.ld_start = 1'b0;
        bus.im_r     = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.ld_busy && g < 10) begin
            tick();
            g++;
        end
        if (g == 10) chk("ld_busy_timeout", 0, 1);
    endtask

    // Full session; gaps insert idle strobes with stray im_r, ld_start and ld_last
    task automatic load_session(input int base, input logic [7:0] bytes[$],
                                input bit gaps, input int fetch_addr);
        start_session(base, fetch_addr);
        model_session(base, bytes, 1'b1);
        for (int k = 0; k < bytes.size(); k++) begin
            if (gaps) begin
                int idle = $urandom_range(0, 2);
                for (int i = 0; i < idle; i++) begin
                    bus.im_r     = 1'b1;
                    bus.addr     = ADDR_W'($urandom_range(0, SPACE - 1));
                    bus.ld_start = 1'($urandom_range(0, 1));
                    bus.ld_base  = ADDR_W'($urandom_range(0, SPACE - 1));
                    bus.ld_last  = 1'($urandom_range(0, 1));
                    tick();
                    bus.im_r     = 1'b0;
                    bus.ld_start = 1'b0;
                    bus.ld_last  = 1'b0;
                end
            end
            send_byte(bytes[k], k == bytes.size() - 1, gaps);
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        bus.im_r = 1'b1; bus.addr = 7'd5;
        bus.ld_start = 1'b0; bus.ld_base = '0;
        bus.ld_valid = 1'b0; bus.ld_byte = '0; bus.ld_last = 1'b0;
        tick(); tick();
        chk("rst_instr_out", bus.instr_out, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_ld_busy", bus.ld_busy, 0);
        chk("rst_ld_done", bus.ld_done, 0);
        chk("rst_ld_err", bus.ld_err, 0);
        chk("rst_ld_count", bus.ld_count, 0);
        bus.im_r = 1'b0;
        reset_n = 1'b1;
        tick();
        fetch(DEPTH + 5);
        tick();

        // Preload every word so later fetches are fully defined
        bq.delete();
        for (int i = 0; i < int'(DEPTH) * 4; i++) bq.push_back(8'($urandom));
        load_session(0, bq, 1'b0, -1);

        bq = '{8'h27, 8'hC0, 8'h00, 8'h00, 8'h38, 8'h00, 8'h00, 8'h03};
        load_session(0, bq, 1'b0, -1);
        fetch(0);
        fetch(1);
        chk("prog_word0", model[0], 32'h27C00000);

        bq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        load_session(10, bq, 1'b1, -1);
        fetch(10);
        fetch(11);
        chk("padded_word11", model[11], 32'h15160000);

        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load_session(DEPTH - 1, bq, 1'b0, 3);
        fetch(DEPTH - 1);
        fetch(DEPTH);
        chk("ld_err_sticky", bus.ld_err, 1);
        start_session(40, -1);
        chk("ld_err_cleared", bus.ld_err, 0);
        chk("ld_ready_in_load", bus.ld_ready, 1);
        bq = '{8'hA1, 8'hA2, 8'hA3};
        model_session(40, bq, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(bq[k], k == 2, 1'b1);
        wait_idle();
        fetch(40);

        // Pointer wraps past the top of the address space
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        load_session(SPACE - 1, bq, 1'b1, -1);
        fetch(0);

        for (int s = 0; s < 25; s++) begin
            int n = $urandom_range(1, 12);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            load_session($urandom_range(0, SPACE - 1), bq, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(0, SPACE - 1) : -1);
            for (int f = 0; f < 4; f++) begin
                fetch($urandom_range(0, SPACE - 1));
                if ($urandom_range(0, 1) == 1) tick();
            end
        end

        // Reset in the middle of the second word keeps the first word only
        start_session(20, -1);
        bq = '{8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h6A, 8'h6B};
        model[20] = 32'h5A5B5C5D;
        for (int k = 0; k < 6; k++) send_byte(bq[k], 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midload_busy", bus.ld_busy, 0);
        chk("midload_ready", bus.ld_ready, 0);
        chk("midload_count", bus.ld_count, 0);
        fetch(20);
        fetch(21);

        tick(); tick(); tick();
        chk("fetch_q_drained", fetch_q.size(), 0);
        chk("load_q_drained", load_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iram_prog.md
Name: iram_prog

Overview:
- Parametrised, run-time-loadable instruction memory for the downsampling processor.
- Generalises the fixed 32-bit, hard-initialised instruction RAM:
  - configurable word width and depth;
  - registered fetch port with valid and address-error flags;
  - byte-serial program loader (ready/valid handshake) so programs are written at run time instead of compiled in.
- Sits between the control unit's PC/fetch stage and an external loader (UART/host bridge).

Parameters:
- DATA_W, 32, instruction width in bits; must be a multiple of 8.
- ADDR_W, 10, fetch/load address width.
- DEPTH, 1024, number of implemented words; must be ≤ 2^ADDR_W.
- BYTES, DATA_W/8, bytes per word (derived; not overridden).

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- im_r  in  1  fetch request.
- addr  in  ADDR_W  fetch address.
- instr_out  out  DATA_W  registered instruction.
- instr_valid  out  1  one-cycle pulse: instr_out updated by a fetch.
- addr_err  out  1  one-cycle pulse: fetch address ≥ DEPTH.
- ld_start  in  1  begin a load session (sampled in IDLE only).
- ld_base  in  ADDR_W  first word address of the session, sampled with ld_start.
- ld_valid  in  1  byte strobe.
- ld_byte  in  8  load data, MSB-first within each word.
- ld_last  in  1  qualifies the final byte of the session.
- ld_ready  out  1  loader accepts bytes.
- ld_busy  out  1  high in LOAD and DONE.
- ld_done  out  1  one-cycle pulse: session complete.
- ld_err  out  1  sticky: a word targeted an address ≥ DEPTH; cleared on next accepted ld_start.
- ld_count  out  ADDR_W+1  words written in current/last session.

Behaviour:
- Reset (reset_n=0 at edge):
  - instr_out=0; instr_valid=0; addr_err=0.
  - ld_ready=0; ld_busy=0; ld_done=0; ld_err=0; ld_count=0.
  - FSM=IDLE; byte index=0; assembly buffer=0.
  - Memory contents NOT cleared.
  - Reset mid-load: partial word discarded; already-written words retained.
- Fetch, IDLE state only. im_r=1 at edge N:
  - addr<DEPTH: instr_out<=mem[addr]; instr_valid=1 during cycle N+1.
  - addr≥DEPTH: instr_out<=0; addr_err=1 and instr_valid=1 during cycle N+1.
  - im_r=0: instr_out holds; instr_valid=0; addr_err=0.
  - Latency: 1 cycle.
- Fetch during LOAD/DONE: im_r ignored; instr_out holds; instr_valid=0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE→LOAD: on ld_start=1. Latches ptr=ld_base; ld_count=0; ld_err=0; byte index=0.
    - ld_start with im_r on the same edge: fetch is served, load starts.
  - LOAD: ld_ready=1. Byte accepted when ld_valid&ld_ready.
    - Buffer shifts left 8 and appends ld_byte; byte index increments.
    - On the accepted byte that completes a word (index=BYTES-1):
      - assembled word written to mem[ptr] on that edge;
      - ptr+1; ld_count+1; index=0.
    - ptr≥DEPTH at write: write dropped; ld_err set; ld_count still increments.
    - ptr increment wraps modulo 2^ADDR_W.
  - ld_last on an accepted byte ending a partial word:
    - remaining low bytes zero-padded; the word is written the same edge.
    - ld_last on a word-completing byte: a normal write, no extra word.
    - Either case: LOAD→DONE.
  - ld_last with ld_valid=0: ignored.
  - ld_start during LOAD/DONE: ignored.
  - DONE: ld_ready=0; ld_done=1 for exactly one cycle; →IDLE next edge.
  - ld_busy=1 in LOAD and DONE.
- Read-after-load: a fetch issued the cycle after ld_done returns the newly written data.

Test Plan:
- Reset, then im_r=1, addr=5 with reset_n=0 → instr_out=0, instr_valid=0. Release, fetch → instr_valid pulses one cycle after im_r.
- ld_start, ld_base=0; bytes 0x27,0xC0,0x00,0x00,0x38,0x00,0x00,0x03 (last on 8th) → ld_done one pulse, ld_count=2. Fetch addr 0 → 0x27C00000; fetch addr 1 → 0x38000003.
- ld_base=10; 6 bytes 0x11..0x16, ld_last on 6th → mem[10]=0x11121314, mem[11]=0x15160000, ld_count=2.
- ld_base=DEPTH-1, 8 bytes → mem[DEPTH-1] written, second word dropped, ld_err=1 until next ld_start. Fetch addr=DEPTH → addr_err pulse, instr_out=0.
- During LOAD, im_r=1 → instr_valid stays 0, instr_out unchanged. Toggle ld_valid with gaps → only strobed bytes counted.
- reset_n=0 after 2 bytes of a word → FSM IDLE, ld_busy=0, previously completed words intact on fetch.
